// File: rtl/sd_image_server_pkg.sv
// Shared types and constants for the SD image server: FSM states and sector geometry.
package sd_image_server_pkg;

    typedef enum logic [3:0] {
        IDLE, ACK, RD_REQ, RD_WAIT, RD_PUT, WR_ADDR, WR_REQ, WR_WAIT, DONE
    } state_e;

    localparam int         SECTOR_BYTES  = 512;
    localparam logic [7:0] FILL_BYTE_DEF = 8'hE5;

endpackage

// File: rtl/edge_det.sv
// Rising-edge detector; stays quiet for the first cycle after reset so a level
// already high at release is not mistaken for a new request.
module edge_det (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sig_i,
    output logic rise_o
);

    logic prev_q;
    logic armed_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            prev_q  <= sig_i;
            armed_q <= 1'b1;
        end
    end

    assign rise_o = armed_q & sig_i & ~prev_q;

endmodule

// File: rtl/sd_image_server.sv
// Serves 512-byte sectors for two virtual SD drives out of a byte-wide image
// memory; out-of-range or unmounted accesses are answered without touching memory.
module sd_image_server
    import sd_image_server_pkg::*;
#(
    parameter int         LBA_W     = 11,
    parameter logic [7:0] FILL_BYTE = FILL_BYTE_DEF
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic [31:0]          sd_lba,
    input  logic [1:0]           sd_rd,
    input  logic [1:0]           sd_wr,
    output logic [1:0]           sd_ack,
    output logic [8:0]           sd_buff_addr,
    output logic [7:0]           sd_buff_dout,
    output logic                 sd_buff_wr,
    input  logic [7:0]           sd_buff_din,
    input  logic [1:0]           img_mounted,
    input  logic [63:0]          img_size,
    output logic [LBA_W+9:0]     mem_addr,
    output logic                 mem_rd,
    output logic                 mem_wr,
    output logic [7:0]           mem_wdata,
    input  logic [7:0]           mem_rdata,
    input  logic                 mem_ready
);

    localparam logic [LBA_W:0] MAX_CNT = {1'b1, {LBA_W{1'b0}}};
    localparam logic [8:0]     LAST    = 9'(SECTOR_BYTES - 1);

    logic [1:0] rd_rise, wr_rise;

    for (genvar g = 0; g < 2; g++) begin : g_edge
        edge_det u_rd (.clk_i(clk_sys), .rst_i(reset), .sig_i(sd_rd[g]), .rise_o(rd_rise[g]));
        edge_det u_wr (.clk_i(clk_sys), .rst_i(reset), .sig_i(sd_wr[g]), .rise_o(wr_rise[g]));
    end

    // Sector count per drive, saturated so oversize images still address the full window.
    logic [54:0]             sz_sec;
    logic [LBA_W:0]          sat_cnt;
    logic [1:0][LBA_W:0]     cnt_q;
    logic                    unused_size_lsbs;

    assign sz_sec           = img_size[63:9];
    assign sat_cnt          = (sz_sec > 55'(MAX_CNT)) ? MAX_CNT : sz_sec[LBA_W:0];
    assign unused_size_lsbs = ^img_size[8:0];

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            for (int d = 0; d < 2; d++)
                if (img_mounted[d]) cnt_q[d] <= sat_cnt;
        end
    end

    state_e           state_q, state_d;
    logic [1:0]       pend_q, pend_d, pwr_q, pwr_d, ack_q, ack_d;
    logic             drv_q, drv_d, wr_q, wr_d, oor_q, oor_d, mem_wr_q, mem_wr_d;
    logic [LBA_W-1:0] lba_q, lba_d;
    logic [8:0]       idx_q, idx_d;
    logic [7:0]       data_q, data_d, wdata_q, wdata_d;

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        pwr_d    = pwr_q;
        ack_d    = ack_q;
        drv_d    = drv_q;
        wr_d     = wr_q;
        oor_d    = oor_q;
        lba_d    = lba_q;
        idx_d    = idx_q;
        data_d   = data_q;
        wdata_d  = wdata_q;
        mem_wr_d = 1'b0;

        // Read wins when both edges land together; repeat edges on a pending drive are dropped.
        for (int d = 0; d < 2; d++) begin
            if (!pend_q[d] && (rd_rise[d] || wr_rise[d])) begin
                pend_d[d] = 1'b1;
                pwr_d[d]  = ~rd_rise[d];
            end
        end

        unique case (state_q)
            IDLE: begin
                if (pend_q[0]) begin
                    drv_d = 1'b0; wr_d = pwr_q[0]; pend_d[0] = 1'b0; state_d = ACK;
                end else if (pend_q[1]) begin
                    drv_d = 1'b1; wr_d = pwr_q[1]; pend_d[1] = 1'b0; state_d = ACK;
                end
            end
            ACK: begin
                lba_d        = sd_lba[LBA_W-1:0];
                oor_d        = (|sd_lba[31:LBA_W]) ||
                               ({1'b0, sd_lba[LBA_W-1:0]} >= cnt_q[drv_q]);
                ack_d[drv_q] = 1'b1;
                idx_d        = '0;
                state_d      = wr_q ? WR_ADDR : RD_REQ;
            end
            RD_REQ: begin
                if (oor_q) begin
                    data_d  = FILL_BYTE;
                    state_d = RD_PUT;
                end else begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (mem_ready) begin
                    data_d  = mem_rdata;
                    state_d = RD_PUT;
                end
            end
            RD_PUT: begin
                if (idx_q == LAST) state_d = DONE;
                else begin idx_d = idx_q + 9'd1; state_d = RD_REQ; end
            end
            WR_ADDR: state_d = WR_REQ;
            WR_REQ: begin
                if (oor_q) begin
                    if (idx_q == LAST) state_d = DONE;
                    else begin idx_d = idx_q + 9'd1; state_d = WR_ADDR; end
                end else begin
                    wdata_d  = sd_buff_din;
                    mem_wr_d = 1'b1;
                    state_d  = WR_WAIT;
                end
            end
            WR_WAIT: begin
                if (mem_ready) begin
                    if (idx_q == LAST) state_d = DONE;
                    else begin idx_d = idx_q + 9'd1; state_d = WR_ADDR; end
                end
            end
            DONE: begin
                ack_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            pend_q   <= '0;
            pwr_q    <= '0;
            ack_q    <= '0;
            drv_q    <= 1'b0;
            wr_q     <= 1'b0;
            oor_q    <= 1'b0;
            lba_q    <= '0;
            idx_q    <= '0;
            data_q   <= '0;
            wdata_q  <= '0;
            mem_wr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            pwr_q    <= pwr_d;
            ack_q    <= ack_d;
            drv_q    <= drv_d;
            wr_q     <= wr_d;
            oor_q    <= oor_d;
            lba_q    <= lba_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            wdata_q  <= wdata_d;
            mem_wr_q <= mem_wr_d;
        end
    end

    assign sd_ack       = ack_q;
    assign sd_buff_addr = idx_q;
    assign sd_buff_dout = data_q;
    assign sd_buff_wr   = (state_q == RD_PUT);
    assign mem_rd       = (state_q == RD_REQ) && !oor_q;
    assign mem_wr       = mem_wr_q;
    assign mem_wdata    = wdata_q;
    assign mem_addr     = {drv_q, lba_q, idx_q};

endmodule

// File: tb/tb_sd_image_server.sv
// Directed bench for sd_image_server: memory responder with 2-cycle latency,
// client write-data model, and logs of strobes and memory requests.
module tb_sd_image_server;

    localparam int LBA_W = 11;
    localparam int AW    = 1 + LBA_W + 9;

    logic          clk_sys = 1'b0;
    logic          reset   = 1'b1;
    logic [31:0]   sd_lba  = '0;
    logic [1:0]    sd_rd   = '0;
    logic [1:0]    sd_wr   = '0;
    logic [1:0]    sd_ack;
    logic [8:0]    sd_buff_addr;
    logic [7:0]    sd_buff_dout;
    logic          sd_buff_wr;
    logic [7:0]    sd_buff_din = '0;
    logic [1:0]    img_mounted = '0;
    logic [63:0]   img_size    = '0;
    logic [AW-1:0] mem_addr;
    logic          mem_rd, mem_wr;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata = '0;
    logic          mem_ready = 1'b0;

    sd_image_server #(.LBA_W(LBA_W), .FILL_BYTE(8'hE5)) dut (
        .clk_sys(clk_sys), .reset(reset), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
        .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
        .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din), .img_mounted(img_mounted),
        .img_size(img_size), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk_sys = ~clk_sys;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    logic          rq1 = 1'b0;
    logic [AW-1:0] a1  = '0;
    logic [AW-1:0] rd_log [8192];
    logic [AW+7:0] wr_log [1024];
    logic [8:0]    s_addr [8192];
    logic [7:0]    s_data [8192];
    int            s_cyc  [8192];
    int            n_rd  = 0;
    int            n_wr  = 0;
    int            n_str = 0;

    always @(posedge clk_sys) begin
        cyc         <= cyc + 1;
        rq1         <= mem_rd | mem_wr;
        a1          <= mem_addr;
        mem_ready   <= rq1;
        mem_rdata   <= a1[7:0];
        sd_buff_din <= sd_buff_addr[7:0] ^ 8'h5A;
        if (mem_rd) begin
            rd_log[n_rd & 8191] <= mem_addr;
            n_rd <= n_rd + 1;
        end
        if (mem_wr) begin
            wr_log[n_wr & 1023] <= {mem_addr, mem_wdata};
            n_wr <= n_wr + 1;
        end
        if (sd_buff_wr) begin
            s_addr[n_str & 8191] <= sd_buff_addr;
            s_data[n_str & 8191] <= sd_buff_dout;
            s_cyc[n_str & 8191]  <= cyc;
            n_str <= n_str + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic mount(input logic [1:0] d, input logic [63:0] sz);
        @(negedge clk_sys);
        img_mounted = d;
        img_size    = sz;
        @(negedge clk_sys);
        img_mounted = '0;
        img_size    = '0;
    endtask

    task automatic wait_on(output logic [1:0] a);
        int n = 0;
        while (sd_ack == 2'b00 && n < 100) begin
            @(negedge clk_sys);
            n++;
        end
        a = sd_ack;
    endtask

    task automatic wait_off(input string tag);
        int n = 0;
        while (sd_ack != 2'b00 && n < 8000) begin
            @(negedge clk_sys);
            n++;
        end
        chk({tag, "_done"}, 64'(sd_ack), 64'd0);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ack"},   64'(sd_ack),       64'd0);
        chk({tag, "_bwr"},   64'(sd_buff_wr),   64'd0);
        chk({tag, "_mrd"},   64'(mem_rd),       64'd0);
        chk({tag, "_mwr"},   64'(mem_wr),       64'd0);
        chk({tag, "_baddr"}, 64'(sd_buff_addr), 64'd0);
        chk({tag, "_bdout"}, 64'(sd_buff_dout), 64'd0);
        chk({tag, "_maddr"}, 64'(mem_addr),     64'd0);
        chk({tag, "_wdata"}, 64'(mem_wdata),    64'd0);
    endtask

    // Strobe i must carry address i and data i[7:0] (memory returns addr[7:0]) or the fill byte.
    task automatic chk_strobes(input string tag, input int s0, input bit fill);
        chk({tag, "_nstrobe"}, 64'(n_str - s0), 64'd512);
        for (int i = 0; i < 512; i++) begin
            chk({tag, "_saddr"}, 64'(s_addr[(s0 + i) & 8191]), 64'(i));
            chk({tag, "_sdata"}, 64'(s_data[(s0 + i) & 8191]), fill ? 64'hE5 : 64'(i & 255));
        end
    endtask

    initial begin
        logic [1:0]    a;
        logic [AW+7:0] e;
        int s0, r0, w0, n;

        // Reset state, with sd_rd[0] already high across the release.
        sd_rd = 2'b01;
        tick(2);
        chk_reset_outs("rst");
        reset = 1'b0;
        tick(10);
        chk("no_edge_after_release", 64'(sd_ack), 64'd0);
        sd_rd = 2'b00;
        tick(2);

        // Drive 0 read, lba 5, 720-sector image.
        mount(2'b01, 64'd368640);
        s0 = n_str; r0 = n_rd;
        sd_lba = 32'd5;
        sd_rd  = 2'b01;
        wait_on(a);
        chk("rd0_ack", 64'(a), 64'h1);
        wait_off("rd0");
        sd_rd = 2'b00;
        chk_strobes("rd0", s0, 1'b0);
        chk("rd0_nmemrd",  64'(n_rd - r0), 64'd512);
        chk("rd0_base",    64'(rd_log[r0 & 8191]), 64'd2560);
        chk("rd0_lastadr", 64'(rd_log[(r0 + 511) & 8191]), 64'd3071);
        tick(3);

        // Drive 1 write, lba 3, oversize image saturates to 2048 sectors.
        mount(2'b10, 64'h1_0000_0000);
        w0 = n_wr; r0 = n_rd;
        sd_lba = 32'd3;
        sd_wr  = 2'b10;
        wait_on(a);
        chk("wr1_ack", 64'(a), 64'h2);
        wait_off("wr1");
        sd_wr = 2'b00;
        chk("wr1_nmemwr", 64'(n_wr - w0), 64'd512);
        chk("wr1_nmemrd", 64'(n_rd - r0), 64'd0);
        for (int i = 0; i < 512; i++) begin
            e = {1'b1, 11'd3, 9'(i), 8'(i) ^ 8'h5A};
            chk("wr1_entry", 64'(wr_log[(w0 + i) & 1023]), 64'(e));
        end
        tick(3);

        // Read at lba == sector count: fill bytes, no memory traffic, one strobe per 2 cycles.
        s0 = n_str; r0 = n_rd;
        sd_lba = 32'd720;
        sd_rd  = 2'b01;
        wait_on(a);
        chk("oor_ack", 64'(a), 64'h1);
        wait_off("oor");
        sd_rd = 2'b00;
        chk_strobes("oor", s0, 1'b1);
        chk("oor_nmemrd", 64'(n_rd - r0), 64'd0);
        chk("oor_spacing", 64'(s_cyc[(s0 + 511) & 8191] - s_cyc[s0 & 8191]), 64'd1022);
        tick(3);

        // Drive 1 raised while drive 0 is busy; then both raised in the same cycle.
        r0 = n_rd;
        sd_lba = 32'd1;
        sd_rd  = 2'b01;
        wait_on(a);
        chk("arb_a_first", 64'(a), 64'h1);
        tick(50);
        sd_rd = 2'b11;
        wait_off("arb_a0");
        wait_on(a);
        chk("arb_a_second", 64'(a), 64'h2);
        wait_off("arb_a1");
        chk("arb_a_nmemrd", 64'(n_rd - r0), 64'd1024);
        chk("arb_a_base0",  64'(rd_log[r0 & 8191]), 64'd512);
        chk("arb_a_base1",  64'(rd_log[(r0 + 512) & 8191]), 64'h100200);
        sd_rd = 2'b00;
        tick(3);
        sd_rd = 2'b11;
        wait_on(a);
        chk("arb_b_first", 64'(a), 64'h1);
        wait_off("arb_b0");
        wait_on(a);
        chk("arb_b_second", 64'(a), 64'h2);
        wait_off("arb_b1");
        sd_rd = 2'b00;
        tick(3);

        // Reset at byte 200 of a read, then a fresh full read.
        s0 = n_str;
        sd_lba = 32'd5;
        sd_rd  = 2'b01;
        n = 0;
        while ((n_str - s0) < 200 && n < 2000) begin
            @(negedge clk_sys);
            n++;
        end
        chk("mid_reached200", 64'((n_str - s0) >= 200), 64'd1);
        reset = 1'b1;
        #1;
        chk_reset_outs("midrst");
        tick(3);
        reset = 1'b0;
        sd_rd = 2'b00;
        tick(6);
        chk("post_rst_idle", 64'(sd_ack), 64'd0);
        mount(2'b01, 64'd368640);
        s0 = n_str; r0 = n_rd;
        sd_lba = 32'd2;
        sd_rd  = 2'b01;
        wait_on(a);
        chk("fresh_ack", 64'(a), 64'h1);
        wait_off("fresh");
        sd_rd = 2'b00;
        chk_strobes("fresh", s0, 1'b0);
        chk("fresh_base", 64'(rd_log[r0 & 8191]), 64'd1024);
        tick(3);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/sd_image_server.md
SD_IMAGE_SERVER -- requirements
Module: sd_image_server

Interface
REQ-001 SHALL have parameter LBA_W, default 11, sector-index bits per drive (2048 sectors = 1 MB per drive).
REQ-002 SHALL have parameter FILL_BYTE, default 8'hE5, byte returned for reads that are out of range or from an unmounted drive.
REQ-003 SHALL have port clk_sys, in, 1, the single clock for all logic.
REQ-004 SHALL have port reset, in, 1; reset is asynchronous and active-high.
REQ-005 SHALL have port sd_lba, in, 32, sector number of the request; held stable by the client while the request is pending.
REQ-006 SHALL have port sd_rd, in, 2, per-drive read request level.
REQ-007 SHALL have port sd_wr, in, 2, per-drive write request level.
REQ-008 SHALL have port sd_ack, out, 2, per-drive transfer-active flag.
REQ-009 SHALL have port sd_buff_addr, out, 9, byte index within the sector.
REQ-010 SHALL have port sd_buff_dout, out, 8, read data to the client.
REQ-011 SHALL have port sd_buff_wr, out, 1, one-cycle strobe qualifying sd_buff_dout.
REQ-012 SHALL have port sd_buff_din, in, 8, write data from the client, valid one cycle after sd_buff_addr changes.
REQ-013 SHALL have port img_mounted, in, 2, per-drive one-cycle pulse marking a new image.
REQ-014 SHALL have port img_size, in, 64, image size in bytes, valid during the img_mounted pulse.
REQ-015 SHALL have ports mem_addr, out, 1+LBA_W+9 bits, and mem_rd, mem_wr, out, 1 each: the image memory request.
REQ-016 SHALL have ports mem_wdata, out, 8; mem_rdata, in, 8; mem_ready, in, 1, a one-cycle completion pulse that carries mem_rdata on reads.

Function
REQ-017 SHALL latch each drive's sector count when its img_mounted pulses, as img_size[63:9] saturated to 2^LBA_W; a size of 0 marks the drive unmounted.
REQ-018 SHALL detect a request on the rising edge of sd_rd[d] or sd_wr[d] and set a per-drive pending flag, recording rd if both edges arrive together.
REQ-019 SHALL set a pending flag even while another transfer is busy; a second edge on an already-pending drive is dropped.
REQ-020 SHALL service pending requests from IDLE with drive 0 having priority over drive 1, and clear the pending flag on entry to ACK.
REQ-021 SHALL use states IDLE, ACK, RD_REQ, RD_WAIT, RD_PUT, WR_ADDR, WR_REQ, WR_WAIT, DONE.
REQ-022 SHALL in ACK: latch the drive and sd_lba[LBA_W-1:0], set sd_ack[d], reset the byte index i to 0, then go to RD_REQ or WR_ADDR.
REQ-023 SHALL form mem_addr as {d, lba, i}.
REQ-024 SHALL on reads: pulse mem_rd for one cycle (RD_REQ), wait for mem_ready (RD_WAIT), then in RD_PUT drive sd_buff_addr=i and sd_buff_dout=data and pulse sd_buff_wr; after i=511 go to DONE, otherwise increment i and return to RD_REQ.
REQ-025 SHALL on writes: drive sd_buff_addr=i (WR_ADDR), sample sd_buff_din the next cycle into mem_wdata with a one-cycle mem_wr pulse (WR_REQ), then wait for mem_ready (WR_WAIT); i=511 goes to DONE.
REQ-026 SHALL treat out-of-range requests (lba >= count, or unmounted drive) as follows: no mem access; reads still produce 512 strobes of FILL_BYTE, one every 2 cycles; writes still sequence sd_buff_addr and discard the data.
REQ-027 SHALL in DONE clear sd_ack and return to IDLE the next cycle.
REQ-028 SHALL keep the 9-bit index from wrapping past 511 mid-transfer.
REQ-029 SHALL hold mem_addr stable from the mem_rd/mem_wr pulse through mem_ready.
REQ-030 SHALL ignore a mem_ready that arrives outside the WAIT states.
REQ-031 SHALL have an img_mounted pulse on the active drive take effect only for the next request.

Reset
REQ-032 SHALL on reset clear sd_ack, sd_buff_wr, mem_rd, mem_wr, sd_buff_addr, sd_buff_dout, mem_addr, mem_wdata, the pending flags, the sector counts and the edge history, and force state to IDLE, including when reset arrives mid-transfer.
REQ-033 SHALL not detect request edges in the first cycle after reset releases, because the edge history register samples first.

Structure
REQ-034 SHALL place the state enum, SECTOR_BYTES=512 and the FILL_BYTE default in package sd_image_server_pkg.
REQ-035 SHALL instantiate the existing edge_det sub-module once per request line (4 total) for request-edge detection.

Verification
REQ-036 Mount drive 0 with size 368640 (720 sectors), raise sd_rd=01 with lba=5, and have memory return data = addr[7:0] with 2-cycle latency -> sd_ack=01, 512 strobes with addrs 0..511 and matching data, mem_addr base 5*512, then sd_ack=00.
REQ-037 Run a drive 1 write with lba=3 and din = index^8'h5A -> 512 mem_wr pulses at {1,3,i}, each mem_wdata matching din.
REQ-038 Read with lba=720 on a 720-sector image -> 512 strobes of 8'hE5 and zero mem_rd pulses.
REQ-039 Raise sd_rd[1] while a drive 0 read is active, and issue a drive 0 request in the same cycle as a drive 1 request -> drive 1 is serviced after drive 0, and drive 0 wins the same-cycle case.
REQ-040 Assert reset at byte 200 of a read -> all outputs are 0 immediately, and a subsequent fresh request completes all 512 bytes.
